// File: rtl/kyber_op_scheduler.sv
// Shares one Kyber core between NUM_REQ requesters: round-robin grant, mode check,
// single-cycle core start, completion wait with a watchdog, per-requester done pulse.
module kyber_op_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]   done,
  output logic [1:0]           err,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 core_start,
  output logic [1:0]           core_mode,
  input  logic                 core_finish,
  output logic                 spurious
);

  localparam int              TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] RR_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_q, gnt_idx, owner_d;
  logic            gnt_found;
  logic [1:0]      gnt_mode, err_d;
  logic [TW-1:0]   timer_q;
  int              idx;

  // Search starts one past the last owner so a held request cannot starve others.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign gnt_mode = req_mode[2*int'(gnt_idx) +: 2];
  assign owner_d  = (state_q == IDLE) ? gnt_idx : grant_id;

  always_comb begin
    state_d = state_q;
    err_d   = err;
    case (state_q)
      IDLE: if (gnt_found) begin
        if (gnt_mode == 2'b11) begin
          state_d = DONE;
          err_d   = 2'b01;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: if (core_finish) begin
        state_d = DONE;
        err_d   = 2'b00;
      end else if (timer_q == T_LAST) begin
        state_d = DONE;
        err_d   = 2'b10;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      done       <= '0;
      err        <= 2'b00;
      busy       <= 1'b0;
      grant_id   <= '0;
      core_start <= 1'b0;
      core_mode  <= 2'b00;
      spurious   <= 1'b0;
      timer_q    <= '0;
      rr_q       <= RR_INIT;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      core_start <= (state_d == ISSUE);
      err        <= err_d;
      done       <= '0;
      if (state_d == DONE) done[owner_d] <= 1'b1;
      // Illegal ops never reach the core, so core_mode keeps its previous value.
      if (state_q == IDLE && gnt_found) begin
        grant_id <= gnt_idx;
        if (gnt_mode != 2'b11) core_mode <= gnt_mode;
      end
      if (state_q == DONE) rr_q <= grant_id;
      if (state_q == ISSUE)
        timer_q <= '0;
      else if (state_q == WAIT && timer_q != '1)
        timer_q <= timer_q + 1'b1;
      if (core_finish && state_q != WAIT) spurious <= 1'b1;
    end
  end

endmodule
